renas_ahb2apb_bridge: RTL and testbench
=======================================

RENAS_AHB2APB_BRIDGE -- requirements
Module: renas_ahb2apb_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AHB/APB address width.
REQ-002 Parameter DATA_WIDTH, default 32: AHB/APB data width.
REQ-003 Parameter NUM_SLV, default 4, power of two: number of APB slave selects.
REQ-004 Parameter SLV_ADDR_BIT, default 12: LSB of the slave-index field in haddr; field width is log2(NUM_SLV).
REQ-005 hclk  in  1  bridge clock, rising edge; the single clock of the block.
REQ-006 hreset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 hsel  in  1  AHB slave select for the peripheral region.
REQ-008 haddr  in  ADDR_WIDTH  AHB address-phase address.
REQ-009 htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-010 hwrite  in  1  AHB direction, 1 = write.
REQ-011 hsize  in  3  AHB transfer size.
REQ-012 hwdata  in  DATA_WIDTH  AHB write data, valid in the data phase.
REQ-013 hready  in  1  bus-level HREADY, indicating the previous transfer has completed.
REQ-014 hreadyout  out  1  slave ready, registered.
REQ-015 hresp  out  1  0 = OKAY, 1 = ERROR, registered.
REQ-016 hrdata  out  DATA_WIDTH  read data, registered.
REQ-017 paddr  out  ADDR_WIDTH  APB address.
REQ-018 psel  out  NUM_SLV  one-hot APB select.
REQ-019 penable  out  1  APB enable.
REQ-020 pwrite  out  1  APB direction.
REQ-021 pwdata  out  DATA_WIDTH  APB write data.
REQ-022 prdata  in  DATA_WIDTH  APB read data.
REQ-023 pready  in  1  APB slave ready.
REQ-024 pslverr  in  1  APB slave error.

Function
REQ-025 The bridge SHALL implement an FSM with states IDLE, WWAIT, SETUP, ACCESS, ERR1 and ERR2.
REQ-026 A transfer SHALL be accepted when the state is IDLE or ERR2 and hsel & htrans[1] & hready = 1; on acceptance the bridge latches haddr, hwrite and hsize.
REQ-027 htrans IDLE or BUSY, or hsel = 0, SHALL cause no state change, and the response SHALL remain OKAY with zero wait states.
REQ-028 An accepted transfer with hsize > 3'b010 SHALL go to ERR1 with no APB access issued.
REQ-029 An accepted read SHALL go to SETUP; an accepted write SHALL go to WWAIT.
REQ-030 WWAIT SHALL last 1 cycle, capture hwdata into pwdata at its closing edge, then go to SETUP.
REQ-031 SETUP SHALL drive psel[idx] = 1 and penable = 0, where idx = latched haddr[SLV_ADDR_BIT +: log2(NUM_SLV)]; SETUP lasts 1 cycle, then goes to ACCESS.
REQ-032 ACCESS SHALL drive psel[idx] = 1 and penable = 1, and SHALL hold there while pready = 0.
REQ-033 paddr, pwrite and pwdata SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-034 In ACCESS with pready = 1 and pslverr = 0, the bridge SHALL go to IDLE; on a read it SHALL register hrdata <= prdata at that edge.
REQ-035 In ACCESS with pready = 1 and pslverr = 1, the bridge SHALL go to ERR1.
REQ-036 ERR1 SHALL drive hresp = 1 and hreadyout = 0, then go to ERR2.
REQ-037 ERR2 SHALL drive hresp = 1 and hreadyout = 1, then go to IDLE, or to the next state per REQ-026 if a new transfer is accepted.
REQ-038 hreadyout SHALL be 1 in IDLE and ERR2, and 0 in WWAIT, SETUP, ACCESS and ERR1.
REQ-039 hresp SHALL be 1 only in ERR1 and ERR2.
REQ-040 psel SHALL be all-zero and penable = 0 outside SETUP and ACCESS.
REQ-041 hrdata SHALL hold its value until the next successful read completion.
REQ-042 Read latency from the acceptance edge SHALL be hreadyout low for 2 + N cycles, where N = extra pready-low cycles; write latency SHALL be 3 + N cycles.

Reset
REQ-043 hreset_n = 0 SHALL immediately force state IDLE and the outputs hreadyout = 1, hresp = 0, hrdata = 0, paddr = 0, psel = 0, penable = 0, pwrite = 0, pwdata = 0.
REQ-044 An assertion of hreset_n during SETUP or ACCESS SHALL abort the APB transfer, with psel and penable deasserted asynchronously.
REQ-045 After hreset_n deasserts, the bridge SHALL accept a new transfer on the first qualifying edge.

Verification
REQ-046 Read with haddr = 0x0000_2004 and pready = 1, prdata = 0xDEADBEEF -> psel = 4'b0100, SETUP then ACCESS; hreadyout low for 2 cycles; hrdata = 0xDEADBEEF with hresp = 0.
REQ-047 Write with haddr = 0x0000_1008 and hwdata = 0x1234_5678, pready low for 2 cycles -> psel = 4'b0010, pwdata = 0x12345678 stable; hreadyout low for 5 cycles.
REQ-048 Read with pslverr = 1 -> hresp = 1 for 2 cycles, hreadyout = 0 then 1; a back-to-back NONSEQ in ERR2 is accepted.
REQ-049 hsize = 3'b011 -> no psel asserted; ERROR response in ERR1/ERR2.
REQ-050 hreset_n pulsed low in ACCESS -> psel and penable go to 0 the same cycle, state IDLE; a following read completes normally.

Source files
------------

// File: rtl/renas_ahb2apb_bridge.sv
// AHB-Lite to APB bridge: one outstanding transfer, registered AHB response,
// one-hot APB select decoded from a slave-index field of the address.
module renas_ahb2apb_bridge #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLV      = 4,
    parameter int SLV_ADDR_BIT = 12
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state;

    logic trans_req;
    logic can_accept;
    logic accept;
    logic size_ok;

    assign trans_req  = (htrans == 2'b10) || (htrans == 2'b11);
    assign can_accept = (state == S_IDLE) || (state == S_ERR2);
    assign accept     = hsel & trans_req & hready & can_accept;
    assign size_ok    = (hsize <= 3'b010);

    function automatic logic [NUM_SLV-1:0] slv_dec(
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [NUM_SLV-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            s[k] = (NUM_SLV == 1) ||
                   (a[SLV_ADDR_BIT +: IDX_W] == IDX_W'(k));
        end
        return s;
    endfunction

    // All outputs are updated together with the state, so each one
    // reflects the state being entered rather than a decode of it.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_ERR2: begin
                    if (accept) begin
                        paddr     <= haddr;
                        pwrite    <= hwrite;
                        hreadyout <= 1'b0;
                        if (!size_ok) begin
                            state <= S_ERR1;
                            hresp <= 1'b1;
                        end else if (hwrite) begin
                            state <= S_WWAIT;
                            hresp <= 1'b0;
                        end else begin
                            state   <= S_SETUP;
                            hresp   <= 1'b0;
                            psel    <= slv_dec(haddr);
                            penable <= 1'b0;
                        end
                    end else begin
                        state     <= S_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
                S_WWAIT: begin
                    state   <= S_SETUP;
                    pwdata  <= hwdata;
                    psel    <= slv_dec(paddr);
                    penable <= 1'b0;
                end
                S_SETUP: begin
                    state   <= S_ACCESS;
                    penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (pready) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            state <= S_ERR1;
                            hresp <= 1'b1;
                        end else begin
                            state     <= S_IDLE;
                            hreadyout <= 1'b1;
                            if (!pwrite) begin
                                hrdata <= prdata;
                            end
                        end
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    psel      <= '0;
                    penable   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_renas_ahb2apb_bridge.sv
// Bench for renas_ahb2apb_bridge: directed cases, then random transfers
// against a memory-backed APB slave and a transaction-level expectation.
module tb_renas_ahb2apb_bridge;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    // single-slave bus: HREADY is this slave's own ready
    assign hready = hreadyout;

    renas_ahb2apb_bridge #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_SLV     (4),
        .SLV_ADDR_BIT(12)
    ) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hwdata   (hwdata),
        .hready   (hready),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    // ---------------- APB slave: 4 slots x 16 words ----------------
    logic [31:0] mem [64];
    bit   [63:0] written;
    logic [7:0]  wait_cfg = 8'd0;
    logic        err_cfg  = 1'b0;
    int          acc_cnt  = 0;
    int          apb_done = 0;
    int          stab_err = 0;
    int          slv_idx;
    logic [31:0] last_pwdata = 32'h0;
    logic [31:0] s_addr = 32'h0;
    logic        s_wr   = 1'b0;
    logic [31:0] s_wd   = 32'h0;

    function automatic int slot_of(input logic [3:0] s);
        case (s)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 + 32'(i * 257);
    endfunction

    always_comb begin
        slv_idx = slot_of(psel) * 16 + int'(paddr[5:2]);
        prdata  = 32'h0;
        if (slot_of(psel) >= 0)
            prdata = written[slv_idx] ? mem[slv_idx] : init_val(slv_idx);
    end

    assign pready  = penable && (acc_cnt >= int'(wait_cfg));
    assign pslverr = penable && err_cfg;

    always @(posedge hclk) begin
        if (psel != 4'b0 && penable) begin
            if (s_addr !== paddr || s_wr !== pwrite ||
                (pwrite && s_wd !== pwdata))
                stab_err <= stab_err + 1;
            if (pready) begin
                acc_cnt  <= 0;
                apb_done <= apb_done + 1;
                if (pwrite) last_pwdata <= pwdata;
                if (pwrite && !pslverr && slot_of(psel) >= 0) begin
                    mem[slv_idx]     <= pwdata;
                    written[slv_idx] <= 1'b1;
                end
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
            if (psel != 4'b0) begin
                s_addr <= paddr;
                s_wr   <= pwrite;
                s_wd   <= pwdata;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [64];
    bit   [63:0] ref_wr;
    logic [31:0] exp_hrdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [31:0] wd,
                           input int waits, input logic err);
        int          low;
        int          rlow;
        int          done0;
        int          idx;
        logic [3:0]  pseen;
        logic        size_bad;
        int          exp_low;
        logic [31:0] rd_val;
        idx      = int'(addr[13:12]) * 16 + int'(addr[5:2]);
        size_bad = (size > 3'd2);
        done0    = apb_done;
        wait_cfg = 8'(waits);
        err_cfg  = err;
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        @(posedge hclk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        @(negedge hclk);
        low   = 0;
        rlow  = 0;
        pseen = 4'b0;
        while (hreadyout !== 1'b1 && low < 40) begin
            low++;
            pseen |= psel;
            if (hresp === 1'b1) rlow++;
            @(negedge hclk);
        end
        pseen |= psel;
        if (size_bad) begin
            check("size_err_low", 32'(low), 32'd1);
            check("size_err_psel", 32'(pseen), 32'd0);
            check("size_err_resp_low", 32'(rlow), 32'd1);
            check("size_err_resp", 32'(hresp), 32'd1);
            check("size_err_no_apb", 32'(apb_done), 32'(done0));
        end else begin
            exp_low = (wr ? 3 : 2) + waits + (err ? 1 : 0);
            check("xfer_low", 32'(low), 32'(exp_low));
            check("xfer_psel", 32'(pseen), 32'(4'b0001 << addr[13:12]));
            check("xfer_resp_low", 32'(rlow), 32'(err));
            check("xfer_resp", 32'(hresp), 32'(err));
            check("xfer_apb_done", 32'(apb_done), 32'(done0 + 1));
            if (wr) begin
                check("xfer_pwdata", last_pwdata, wd);
                if (!err) begin
                    ref_mem[idx] = wd;
                    ref_wr[idx]  = 1'b1;
                end
            end else if (!err) begin
                rd_val     = ref_wr[idx] ? ref_mem[idx] : init_val(idx);
                exp_hrdata = rd_val;
            end
        end
        check("hrdata", hrdata, exp_hrdata);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        hreset_n = 1'b0;
        hsel     = 1'b0;
        haddr    = 32'h0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hsize    = 3'd2;
        hwdata   = 32'h0;
        ref_wr   = '0;
        repeat (3) @(negedge hclk);
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        hreset_n = 1'b1;
        @(negedge hclk);

        // IDLE / BUSY / unselected give no activity
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h2000;
        @(negedge hclk);
        hsel = 1'b0; htrans = 2'b10;
        @(negedge hclk);
        check("busy_hreadyout", 32'(hreadyout), 32'd1);
        check("busy_hresp", 32'(hresp), 32'd0);
        check("busy_psel", 32'(psel), 32'd0);
        htrans = 2'b00;

        do_xfer(32'h0000_2004, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0);
        do_xfer(32'h0000_2004, 1'b0, 3'd2, 32'h0, 0, 1'b0);
        do_xfer(32'h0000_1008, 1'b1, 3'd2, 32'h1234_5678, 2, 1'b0);
        do_xfer(32'h0000_3000, 1'b0, 3'd2, 32'h0, 0, 1'b1);
        check("err2_state_resp", 32'(hresp), 32'd1);
        do_xfer(32'h0000_1008, 1'b0, 3'd2, 32'h0, 1, 1'b0);
        do_xfer(32'h0000_0000, 1'b0, 3'b011, 32'h0, 0, 1'b0);
        do_xfer(32'h0000_0004, 1'b1, 3'd1, 32'hA5A5_0F0F, 0, 1'b0);

        // reset pulse while the APB access is waiting on pready
        wait_cfg = 8'd6; err_cfg = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_3010;
        hwrite = 1'b0; hsize = 3'd2;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        check("abort_setup_psel", 32'(psel), 32'(4'b1000));
        @(negedge hclk);
        check("abort_access_en", 32'(penable), 32'd1);
        #2 hreset_n = 1'b0;
        #1;
        check("abort_psel", 32'(psel), 32'd0);
        check("abort_penable", 32'(penable), 32'd0);
        check("abort_hreadyout", 32'(hreadyout), 32'd1);
        check("abort_hrdata", hrdata, 32'd0);
        exp_hrdata = 32'h0;
        @(negedge hclk);
        hreset_n = 1'b1;
        do_xfer(32'h0000_3010, 1'b0, 3'd2, 32'h0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 12) |
                (32'($urandom_range(0, 15)) << 2);
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 :
                 3'($urandom_range(0, 2));
            do_xfer(a, 1'($urandom_range(0, 1)), sz, $urandom,
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0));
        end

        check("apb_stable", 32'(stab_err), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
